// File: rtl/fns_dec_seq_ctrl_if.sv
// Handshake bundle between the TSV receive register, the decode sequencer
// and the data sink: an input word channel and an output word channel.
interface fns_dec_seq_ctrl_if #(
  parameter int NGRP = 4,
  parameter int CW   = 23,
  parameter int DW   = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NGRP*CW-1:0]   codein;
  logic                 out_valid;
  logic                 out_ready;
  logic [NGRP*DW-1:0]   dataout;

  // Sequencer side: consumes codewords, produces decoded words.
  modport slave (
    input  in_valid, codein, out_ready,
    output in_ready, out_valid, dataout
  );

  // Environment side: supplies codewords, sinks decoded words.
  modport master (
    output in_valid, codein, out_ready,
    input  in_ready, out_valid, dataout
  );
endinterface

// File: rtl/fns_dec_seq_ctrl.sv
// Time-multiplexes one shared combinational FNS decoder across NGRP codeword
// groups. A bus word is latched into a shadow register, one group per cycle
// is presented on dec_code, and the returned slice is stored into dataout.
// The finished word is held in DONE until the sink accepts it; an accepted
// output can be overlapped with loading the next word (DONE -> RUN).
module fns_dec_seq_ctrl #(
  parameter int NGRP = 4,
  parameter int CW   = 23,
  parameter int DW   = 16,
  parameter int IW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  fns_dec_seq_ctrl_if.slave     bus,
  output logic [CW-1:0]         dec_code,
  input  logic [DW-1:0]         dec_data,
  output logic                  busy,
  output logic [IW-1:0]         grp_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NGRP*CW-1:0]   shadow_q;
  logic [NGRP*DW-1:0]   dataout_q;
  logic                 load_d;
  logic                 in_ready_d;
  logic                 last_grp_d;
  logic [CW-1:0]        dec_code_d;

  // The index is cleared explicitly at the last group, so NGRP need not be 2**IW.
  assign last_grp_d = (idx_q == IW'(NGRP - 1));

  // Next-state, index and input-acceptance decode.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    load_d     = 1'b0;
    in_ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid) begin
          load_d  = 1'b1;
          idx_d   = {IW{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_grp_d) begin
          idx_d   = {IW{1'b0}};
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        // Output handshake and next input share the same edge.
        in_ready_d = bus.out_ready;
        if (bus.out_ready && bus.in_valid) begin
          load_d  = 1'b1;
          idx_d   = {IW{1'b0}};
          state_d = ST_RUN;
        end else if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        idx_d   = {IW{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, group index and shadow copy of the accepted bus word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= {IW{1'b0}};
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load_d) begin
        shadow_q <= bus.codein;
      end
    end
  end

  // Group mux towards the decoder; zero whenever no group is being decoded.
  always_comb begin
    dec_code_d = {CW{1'b0}};
    for (int g = 0; g < NGRP; g++) begin
      dec_code_d = ((state_q == ST_RUN) && (idx_q == IW'(g)))
                   ? shadow_q[g*CW +: CW] : dec_code_d;
    end
  end

  // Capture the decoded slice for the group currently on the decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataout_q <= '0;
    end else begin
      for (int g = 0; g < NGRP; g++) begin
        if ((state_q == ST_RUN) && (idx_q == IW'(g))) begin
          dataout_q[g*DW +: DW] <= dec_data;
        end
      end
    end
  end

  assign dec_code      = dec_code_d;
  assign busy          = (state_q == ST_RUN);
  assign grp_idx       = (state_q == ST_RUN) ? idx_q : {IW{1'b0}};
  assign bus.in_ready  = in_ready_d;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.dataout   = dataout_q;

endmodule
